// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//
// Shared declarations for the UART transmitter and receiver:
//   - uart_state_e         : frame state enumeration (IDLE, START, DATA, PARITY,
//                            STOP). The receiver uses the same encoding.
//   - DATA_BITS            : payload bits per frame (8).
//   - START_LEVEL          : line level of the start bit (0).
//   - STOP_LEVEL           : line level of the stop bit and of the idle line (1).
//   - CLKS_PER_BIT_DEFAULT : default clocks per serial bit (5208).
//   - BAUD_CNT_W           : width of the bit-period counter. 16 bits covers the
//                            legal CLKS_PER_BIT range of 2..65535.
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int   DATA_BITS            = 8;
  localparam logic START_LEVEL          = 1'b0;
  localparam logic STOP_LEVEL           = 1'b1;
  localparam int   CLKS_PER_BIT_DEFAULT = 5208;
  localparam int   BAUD_CNT_W           = 16;

endpackage : uart_pkg

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
//
// Bit-period counter shared by the UART transmitter and receiver. While run is
// high the counter steps 0..CLKS_PER_BIT-1 and then wraps to 0. tick is high
// during the last cycle of each bit period, so the owner advances its state on
// the same edge where the counter wraps. While run is low the counter is held
// at 0, which means every new frame starts with a full bit period.
//
// Parameters:
//   CLKS_PER_BIT : clocks per serial bit, legal range 2..65535
//
// Ports:
//   clk  : in  - clock, rising edge
//   clr  : in  - asynchronous active-high reset; forces the counter to 0
//   run  : in  - count enable; low holds the counter at 0
//   tick : out - high in the final cycle of a bit period (wrap cycle)
// -----------------------------------------------------------------------------
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam logic [BAUD_CNT_W-1:0] LAST_CNT = BAUD_CNT_W'(CLKS_PER_BIT - 1);

  logic [BAUD_CNT_W-1:0] cnt_q;
  logic [BAUD_CNT_W-1:0] cnt_d;

  // NOTE: every signal written here gets a default first, so no path through
  // the block can leave a value unassigned and infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (!run) begin
      cnt_d = '0;
    end else if (cnt_q == LAST_CNT) begin
      cnt_d = '0;
      tick  = 1'b1;
    end else begin
      cnt_d = cnt_q + BAUD_CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. Every flop then
  // samples its pre-edge value, whatever order the simulator runs the blocks.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : uart_baud_tick

// File: rtl/uart_transmitter.sv
// -----------------------------------------------------------------------------
// uart_transmitter
//
// Serialises one byte per four-phase req/ack handshake. Frame format:
//   start (0), data[0]..data[7] LSB first, [even parity], stop (1).
//
// Build option:
//   UART_TX_PARITY_EN : when defined, a PARITY bit period is inserted between
//                       DATA and STOP that carries the XOR of the latched byte
//                       (11 bit periods per frame). When undefined the FSM
//                       goes straight from DATA to STOP (10 bit periods).
//
// Parameters:
//   CLKS_PER_BIT : clocks per serial bit, legal range 2..65535
//
// Ports:
//   clk  : in  - clock, rising edge
//   clr  : in  - asynchronous active-high reset; aborts any frame in progress
//   req  : in  - upstream request; data is valid while req is high
//   data : in  - byte to send; sampled only on the accepting edge
//   ack  : out - handshake acknowledge. Rises on acceptance and falls on the
//                first clock req is seen low, in any frame state.
//   txd  : out - serial line, registered; idles high
//   busy : out - high while a frame is being driven on txd
//
// Timing: the edge that accepts a byte also drives the start bit, so txd goes
// low one clock after req rises. The edge that ends STOP returns to IDLE with
// busy low. If req is high and ack is low at that point, the next START begins
// one clock later, which gives a one-clock idle gap between frames.
// -----------------------------------------------------------------------------
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       req,
  input  logic [7:0] data,
  output logic       ack,
  output logic       txd,
  output logic       busy
);

  localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

  uart_state_e          state_q,   state_d;
  logic [2:0]           bit_idx_q, bit_idx_d;   // data bit currently on txd
  logic [DATA_BITS-1:0] shift_q,   shift_d;     // bits not yet sent, LSB next
  logic                 txd_q,     txd_d;
  logic                 ack_q,     ack_d;
  logic                 busy_q,    busy_d;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q,  parity_d;    // even parity of latched byte
`endif

  logic run;
  logic tick;
  logic accept;

  // The bit timer runs for the whole frame and rests at 0 in IDLE. START
  // therefore always lasts exactly CLKS_PER_BIT clocks after acceptance.
  assign run = (state_q != IDLE);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk (clk),
    .clr (clr),
    .run (run),
    .tick(tick)
  );

  // Next-state logic. Each transition out of START/DATA/PARITY/STOP happens
  // on the tick edge. The bit for the new period is loaded into txd_d at the
  // same time, so txd changes exactly at bit boundaries.
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    txd_d     = txd_q;
    ack_d     = ack_q;
    busy_d    = busy_q;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    // While ack is high the current handshake is still open, so a held req
    // must not start another frame.
    accept = (state_q == IDLE) && req && !ack_q;

    // ack is independent of the frame, so the handshake can close mid-frame.
    if (accept) begin
      ack_d = 1'b1;
    end else if (ack_q && !req) begin
      ack_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          shift_d   = data;
`ifdef UART_TX_PARITY_EN
          parity_d  = ^data;
`endif
          bit_idx_d = '0;
          txd_d     = START_LEVEL;
          busy_d    = 1'b1;
          state_d   = START;
        end
      end

      START: begin
        if (tick) begin
          txd_d     = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end

      DATA: begin
        if (tick) begin
          if (bit_idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
            txd_d   = parity_q;
            state_d = PARITY;
`else
            txd_d   = STOP_LEVEL;
            state_d = STOP;
`endif
          end else begin
            txd_d     = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          txd_d   = STOP_LEVEL;
          state_d = STOP;
        end
      end
`endif

      STOP: begin
        if (tick) begin
          // The line stays at the stop level and becomes the idle level.
          txd_d     = STOP_LEVEL;
          busy_d    = 1'b0;
          bit_idx_d = '0;
          state_d   = IDLE;
        end
      end

      default: begin
        // This covers PARITY when the parity option is not built, and any
        // illegal encoding. Return to a safe idle line.
        txd_d     = STOP_LEVEL;
        busy_d    = 1'b0;
        bit_idx_d = '0;
        state_d   = IDLE;
      end
    endcase
  end

  // All frame state is in one register block. The shift register is reset
  // together with the control state, so an aborted frame leaves no data behind.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= IDLE;
      bit_idx_q <= '0;
      shift_q   <= '0;
      txd_q     <= STOP_LEVEL;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign txd  = txd_q;
  assign ack  = ack_q;
  assign busy = busy_q;

endmodule : uart_transmitter

// File: tb/tb_uart_transmitter.sv
// -----------------------------------------------------------------------------
// tb_uart_transmitter
//
// Directed bench for uart_transmitter with CLKS_PER_BIT = 4. Inputs change and
// outputs are sampled on the falling clock edge. Sample n (n >= 1) after req
// rises at a falling edge therefore shows the state after the n-th rising
// edge. Define UART_TX_PARITY_EN to build and check the parity variant.
// -----------------------------------------------------------------------------
module tb_uart_transmitter;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       clr;
  logic       req;
  logic [7:0] data;
  logic       ack;
  logic       txd;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_transmitter #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk (clk),
    .clr (clr),
    .req (req),
    .data(data),
    .ack (ack),
    .txd (txd),
    .busy(busy)
  );

  // Expected line level for bit period k of a frame carrying byte b.
  function automatic logic exp_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Samples one whole frame starting at the falling edge after acceptance.
  // txd must match the expected bit and busy must be high on every sample.
  // Optional actions are applied after sample s (0-based):
  //   s == 0        : data <= mid_data (data change after acceptance)
  //   s == drop_at  : req  <= 0; ack must be low on the next sample
  //   s == raise_at : req  <= 1, data <= raise_data
  task automatic check_frame(input logic [7:0] b, input string tag,
                             input logic [7:0] mid_data, input int drop_at,
                             input int raise_at, input logic [7:0] raise_data);
    int   s;
    logic bad;
    logic got_txd;
    logic got_busy;
    s = 0;
    for (int k = 0; k < NBITS; k++) begin
      bad      = 1'b0;
      got_txd  = exp_bit(b, k);
      got_busy = 1'b1;
      for (int j = 0; j < CPB; j++) begin
        @(negedge clk);
        if (s == 0) begin
          checks++;
          if (ack !== 1'b1) begin
            failures++;
            $display("FAIL %s ack_rise: ack=%b expected 1", tag, ack);
          end
        end
        if (drop_at >= 0 && s == drop_at + 1) begin
          checks++;
          if (ack !== 1'b0) begin
            failures++;
            $display("FAIL %s ack_clear_midframe: ack=%b expected 0", tag, ack);
          end
        end
        if (!bad && (txd !== exp_bit(b, k) || busy !== 1'b1)) begin
          bad      = 1'b1;
          got_txd  = txd;
          got_busy = busy;
        end
        if (s == 0) data = mid_data;
        if (s == drop_at) req = 1'b0;
        if (s == raise_at) begin
          req  = 1'b1;
          data = raise_data;
        end
        s++;
      end
      checks++;
      if (bad) begin
        failures++;
        $display("FAIL %s bit%0d: txd=%b busy=%b expected txd=%b busy=1",
                 tag, k, got_txd, got_busy, exp_bit(b, k));
      end
    end
  endtask

  // One clock after a frame ends: the line is idle and busy is low.
  task automatic idle_check(input string tag);
    @(negedge clk);
    checks++;
    if (txd !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s idle: txd=%b busy=%b expected txd=1 busy=0", tag, txd, busy);
    end
  endtask

  task automatic test_reset();
    clr  = 1'b1;
    req  = 1'b0;
    data = 8'h00;
    repeat (2) @(negedge clk);
    checks++;
    if (txd !== 1'b1) begin
      failures++;
      $display("FAIL reset_txd: txd=%b expected 1", txd);
    end
    checks++;
    if (ack !== 1'b0) begin
      failures++;
      $display("FAIL reset_ack: ack=%b expected 0", ack);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy: busy=%b expected 0", busy);
    end
    clr = 1'b0;
    @(negedge clk);
  endtask

  // A5 -> start, 1,0,1,0,0,1,0,1, stop; busy high for exactly NBITS*4 clocks.
  task automatic test_basic();
    req  = 1'b1;
    data = 8'hA5;
    check_frame(8'hA5, "basic_a5", 8'hA5, -1, -1, 8'h00);
    req = 1'b0;
    idle_check("basic_a5");
    checks++;
    if (ack !== 1'b0) begin
      failures++;
      $display("FAIL basic_ack_clear: ack=%b expected 0", ack);
    end
  endtask

  // req held through two frame lengths yields one frame only.
  task automatic test_hold();
    logic quiet;
    req  = 1'b1;
    data = 8'hC3;
    check_frame(8'hC3, "hold_f1", 8'hC3, -1, -1, 8'h00);
    quiet = 1'b1;
    for (int i = 0; i < NBITS * CPB; i++) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0 || ack !== 1'b1) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      failures++;
      $display("FAIL hold_no_second_frame: activity seen, expected txd=1 busy=0 ack=1");
    end
    req = 1'b0;
    @(negedge clk);
    checks++;
    if (ack !== 1'b0) begin
      failures++;
      $display("FAIL hold_ack_clear: ack=%b expected 0", ack);
    end
    req  = 1'b1;
    data = 8'h3C;
    check_frame(8'h3C, "hold_f2", 8'h3C, -1, -1, 8'h00);
    req = 1'b0;
    idle_check("hold_f2");
  endtask

  // data changed to FF right after acceptance; the line still carries 5A.
  task automatic test_data_change();
    req  = 1'b1;
    data = 8'h5A;
    check_frame(8'h5A, "latch_5a", 8'hFF, -1, -1, 8'h00);
    req = 1'b0;
    idle_check("latch_5a");
  endtask

  // Handshake closes mid-frame and req rises again during the frame; the second
  // start bit follows the first stop bit after exactly one idle clock.
  task automatic test_mid_handshake();
    req  = 1'b1;
    data = 8'h96;
    check_frame(8'h96, "hs_f1", 8'h96, 10, 30, 8'h00);
    idle_check("hs_gap");
    check_frame(8'h00, "hs_f2", 8'h00, -1, -1, 8'h00);
    req = 1'b0;
    idle_check("hs_f2");
  endtask

  // Reset during data bit 3 of A5 (a 0 bit) aborts the frame at once.
  task automatic test_reset_mid();
    logic quiet;
    req  = 1'b1;
    data = 8'hA5;
    repeat (18) @(negedge clk);
    checks++;
    if (txd !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL abort_pre: txd=%b busy=%b expected txd=0 busy=1", txd, busy);
    end
    clr = 1'b1;
    #1;
    checks++;
    if (txd !== 1'b1 || busy !== 1'b0 || ack !== 1'b0) begin
      failures++;
      $display("FAIL abort_async: txd=%b busy=%b ack=%b expected 1 0 0", txd, busy, ack);
    end
    req = 1'b0;
    @(negedge clk);
    clr   = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0 || ack !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      failures++;
      $display("FAIL abort_quiet: activity after reset, expected txd=1 busy=0 ack=0");
    end
    req  = 1'b1;
    data = 8'h3C;
    check_frame(8'h3C, "abort_recover", 8'h3C, -1, -1, 8'h00);
    req = 1'b0;
    idle_check("abort_recover");
  endtask

`ifdef UART_TX_PARITY_EN
  // 07 has three ones -> parity 1; 03 has two ones -> parity 0.
  task automatic test_parity();
    req  = 1'b1;
    data = 8'h07;
    check_frame(8'h07, "parity_07", 8'h07, -1, -1, 8'h00);
    req = 1'b0;
    idle_check("parity_07");
    req  = 1'b1;
    data = 8'h03;
    check_frame(8'h03, "parity_03", 8'h03, -1, -1, 8'h00);
    req = 1'b0;
    idle_check("parity_03");
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clr  = 1'b1;
    req  = 1'b0;
    data = 8'h00;
    test_reset();
    test_basic();
    test_hold();
    test_data_change();
    test_mid_handshake();
    test_reset_mid();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_uart_transmitter

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 5208, clock cycles per serial bit; legal range 2..65535.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port clr, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port req, input, 1, upstream request: a byte is valid on data.
REQ-005 SHALL have port data, input, 8, the byte to send; sampled only at acceptance.
REQ-006 SHALL have port ack, output, 1, four-phase handshake acknowledge.
REQ-007 SHALL have port txd, output, 1, serial line; idles high.
REQ-008 SHALL have port busy, output, 1, high while a frame is on txd.

Function
REQ-009 SHALL use the frame: start bit (0), data[0] through data[7] LSB first, optional parity bit (REQ-021), stop bit (1).
REQ-010 SHALL accept a byte only in state IDLE with req=1 and ack=0.
REQ-011 SHALL, on the edge that accepts, latch data into an internal shift register, set ack=1 and busy=1, drive txd=0, and enter START; latency from req to the first start-bit cycle is 1 clock.
REQ-012 SHALL hold every bit on txd for exactly CLKS_PER_BIT clocks; one bit-period counter counts 0..CLKS_PER_BIT-1 and wraps to 0 as each bit ends.
REQ-013 SHALL follow the state sequence IDLE -> START -> DATA (8 bit periods, 3-bit index 0..7) -> [PARITY] -> STOP -> IDLE; each transition happens when the bit counter wraps.
REQ-014 SHALL clear busy and drive txd=1 on the clock that STOP ends; IDLE returns the same clock.
REQ-015 SHALL clear ack on the first clock on which req is sampled 0 while ack=1; this is independent of the frame state, so the handshake can finish mid-frame.
REQ-016 SHALL NOT start a new frame while ack=1; a req held high through the end of STOP is not re-accepted until req falls, ack falls, and req rises again.
REQ-017 SHALL allow back-to-back frames: if ack=0 and req=1 on the clock IDLE is entered, the next START begins on the following clock, giving a minimum 1-clock idle gap.
REQ-018 SHALL ignore changes on data after acceptance; the frame uses the latched byte.

Reset
REQ-019 SHALL, while clr=1, force txd=1, ack=0, busy=0, state IDLE, bit counter 0, bit index 0, shift register 0, independent of clk.
REQ-020 SHALL abort a frame in progress when reset is asserted; on release, txd stays high and the next frame needs a fresh req rising edge with ack=0.

Configuration
REQ-021 SHALL compile in the PARITY state when macro UART_TX_PARITY_EN is defined: one bit period carrying the even parity (XOR) of the 8 latched data bits, between DATA and STOP; frame length 11 bit periods.
REQ-022 SHALL, when UART_TX_PARITY_EN is undefined, go directly DATA -> STOP and contain no parity logic; frame length 10 bit periods.

Structure
REQ-023 SHALL take from shared package uart_pkg: the state enumeration (IDLE, START, DATA, PARITY, STOP), the frame constants DATA_BITS=8, START_LEVEL=0, STOP_LEVEL=1, and the default CLKS_PER_BIT.
REQ-024 SHALL put the bit-period counter in sub-module uart_baud_tick (inputs clk, clr, run; output tick on the wrap); the receiver uses the same sub-module.

Verification (CLKS_PER_BIT=4 unless stated)
REQ-025 SHALL check that req=1 with data=8'hA5 gives txd = 0 for 4 clocks, then 1,0,1,0,0,1,0,1 for 4 clocks each, then 1 for 4 clocks; busy is high for 40 clocks and ack rises 1 clock after req.
REQ-026 SHALL check that with UART_TX_PARITY_EN and data=8'h07, the parity bit is 1 and busy is high for 44 clocks; with data=8'h03, the parity bit is 0.
REQ-027 SHALL check that req held high through two frame lengths gives exactly one frame; dropping req clears ack 1 clock later, and a new req then starts the second frame.
REQ-028 SHALL check that asserting clr during data bit 3 immediately gives txd=1, busy=0, ack=0, and no further edges on txd until the next accepted req.
REQ-029 SHALL check that a handshake finished mid-frame followed by req=1 with data=8'h00 before STOP ends gives the second start bit exactly 1 clock after the first stop bit ends.
REQ-030 SHALL check that changing data to 8'hFF during the frame leaves the serialized byte 8'h5A unchanged.
